// File: rtl/emissor_if.sv
// CPU/bus/snoop signal bundle of the emissor MSI controller.
// master = the emissor itself, slave = the CPU/bus/snoop environment driving it.
interface emissor_if #(
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned TAG_W   = 4
);
  localparam int unsigned A = TAG_W + INDEX_W;

  logic         i_Cpu_Valid;
  logic         i_Cpu_Write;
  logic [A-1:0] i_Cpu_Addr;
  logic         o_Cpu_Ready;
  logic         o_Cpu_Hit;

  logic         o_Bus_Req;
  logic         i_Bus_Grant;
  logic         o_Bus_Valid;
  logic [1:0]   o_Operation;
  logic [A-1:0] o_Bus_Addr;

  logic         o_Writeback;
  logic [A-1:0] o_Wb_Addr;

  logic         i_Snoop_Valid;
  logic [1:0]   i_Snoop_Operation;
  logic [A-1:0] i_Snoop_Addr;
  logic         o_Flush;
  logic [A-1:0] o_Flush_Addr;

  modport master (
    input  i_Cpu_Valid, i_Cpu_Write, i_Cpu_Addr, i_Bus_Grant,
           i_Snoop_Valid, i_Snoop_Operation, i_Snoop_Addr,
    output o_Cpu_Ready, o_Cpu_Hit, o_Bus_Req, o_Bus_Valid, o_Operation,
           o_Bus_Addr, o_Writeback, o_Wb_Addr, o_Flush, o_Flush_Addr
  );

  modport slave (
    output i_Cpu_Valid, i_Cpu_Write, i_Cpu_Addr, i_Bus_Grant,
           i_Snoop_Valid, i_Snoop_Operation, i_Snoop_Addr,
    input  o_Cpu_Ready, o_Cpu_Hit, o_Bus_Req, o_Bus_Valid, o_Operation,
           o_Bus_Addr, o_Writeback, o_Wb_Addr, o_Flush, o_Flush_Addr
  );
endinterface

// File: rtl/emissor.sv
// Processor-side MSI controller: per-line tag/state of a direct-mapped cache,
// CPU requests turned into snooping-bus operations, snooped ops applied to own lines.
module emissor #(
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned TAG_W   = 4
) (
  input logic       i_Clock,
  input logic       i_Reset_n,
  emissor_if.master bus
);
  localparam int unsigned A     = TAG_W + INDEX_W;
  localparam int unsigned LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, BUS_REQ, BUS_ISSUE, DONE} state_t;
  typedef enum logic [1:0] {LS_I = 2'b00, LS_S = 2'b01, LS_M = 2'b10} line_t;
  typedef enum logic [1:0] {
    OP_READ_MISS  = 2'b00,
    OP_INVALIDATE = 2'b01,
    OP_WRITE_MISS = 2'b10,
    OP_NONE       = 2'b11
  } op_t;

  state_t             state, next_state;
  line_t              line_state [LINES];
  logic [TAG_W-1:0]   line_tag   [LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               req_write;
  op_t                pend_op, pend_op_next;
  logic               hit_q, hit_next;

  line_t              cur_state;
  logic [TAG_W-1:0]   cur_tag;
  logic               lk_hit;

  logic [INDEX_W-1:0] snp_idx;
  logic [TAG_W-1:0]   snp_tag;
  logic               snp_match, snp_kill, snp_down, snp_blocked, snp_apply;

  logic               cpu_ready_d, cpu_hit_d, bus_req_d, bus_valid_d;
  logic [1:0]         operation_d;
  logic [A-1:0]       bus_addr_d, wb_addr_d, flush_addr_d;
  logic               writeback_d, flush_d;

  assign cur_state = line_state[req_idx];
  assign cur_tag   = line_tag[req_idx];
  assign lk_hit    = (cur_state != LS_I) && (cur_tag == req_tag);

  assign snp_idx   = bus.i_Snoop_Addr[INDEX_W-1:0];
  assign snp_tag   = bus.i_Snoop_Addr[A-1:INDEX_W];
  assign snp_match = bus.i_Snoop_Valid && (bus.i_Snoop_Operation != OP_NONE) &&
                     (line_state[snp_idx] != LS_I) && (line_tag[snp_idx] == snp_tag);
  assign snp_kill  = snp_match && ((bus.i_Snoop_Operation == OP_INVALIDATE) ||
                                   (bus.i_Snoop_Operation == OP_WRITE_MISS));
  assign snp_down  = snp_match && (bus.i_Snoop_Operation == OP_READ_MISS) &&
                     (line_state[snp_idx] == LS_M);
  // Own writeback/fill of the same line overrides a concurrent snoop.
  assign snp_blocked = ((state == WRITEBACK) || (state == BUS_ISSUE)) && (snp_idx == req_idx);
  assign snp_apply   = snp_match && !snp_blocked;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= IDLE;
      pend_op   <= OP_READ_MISS;
      hit_q     <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_write <= 1'b0;
    end else begin
      state   <= next_state;
      pend_op <= pend_op_next;
      hit_q   <= hit_next;
      if (state == IDLE && bus.i_Cpu_Valid) begin
        req_tag   <= bus.i_Cpu_Addr[A-1:INDEX_W];
        req_idx   <= bus.i_Cpu_Addr[INDEX_W-1:0];
        req_write <= bus.i_Cpu_Write;
      end
    end
  end

  always_comb begin
    next_state   = state;
    pend_op_next = pend_op;
    hit_next     = hit_q;
    case (state)
      IDLE: if (bus.i_Cpu_Valid) next_state = LOOKUP;
      LOOKUP: begin
        hit_next = 1'b0;
        if (lk_hit && (!req_write || cur_state == LS_M)) begin
          next_state = DONE;
          hit_next   = 1'b1;
        end else if (lk_hit) begin
          next_state   = BUS_REQ;
          pend_op_next = OP_INVALIDATE;
        end else begin
          pend_op_next = req_write ? OP_WRITE_MISS : OP_READ_MISS;
          next_state   = (cur_state == LS_M) ? WRITEBACK : BUS_REQ;
        end
      end
      WRITEBACK: next_state = BUS_REQ;
      BUS_REQ:   if (bus.i_Bus_Grant) next_state = BUS_ISSUE;
      BUS_ISSUE: next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    // Losing the line before the INVALIDATE is issued (including a snoop racing
    // the LOOKUP edge) means we no longer hold a copy: fetch it with WRITE_MISS.
    if ((state == LOOKUP || state == BUS_REQ) && pend_op_next == OP_INVALIDATE &&
        snp_kill && snp_idx == req_idx)
      pend_op_next = OP_WRITE_MISS;
  end

  always_comb begin
    cpu_ready_d  = (next_state == DONE);
    cpu_hit_d    = (next_state == DONE) && hit_next;
    bus_req_d    = (next_state == BUS_REQ);
    bus_valid_d  = (next_state == BUS_ISSUE);
    operation_d  = '0;
    bus_addr_d   = '0;
    if (next_state == BUS_ISSUE) begin
      operation_d = pend_op_next;
      bus_addr_d  = {req_tag, req_idx};
    end
    writeback_d  = (next_state == WRITEBACK);
    wb_addr_d    = (next_state == WRITEBACK) ? {cur_tag, req_idx} : '0;
    flush_d      = snp_down && snp_apply;
    flush_addr_d = flush_d ? bus.i_Snoop_Addr : '0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      bus.o_Cpu_Ready  <= 1'b0;
      bus.o_Cpu_Hit    <= 1'b0;
      bus.o_Bus_Req    <= 1'b0;
      bus.o_Bus_Valid  <= 1'b0;
      bus.o_Operation  <= '0;
      bus.o_Bus_Addr   <= '0;
      bus.o_Writeback  <= 1'b0;
      bus.o_Wb_Addr    <= '0;
      bus.o_Flush      <= 1'b0;
      bus.o_Flush_Addr <= '0;
    end else begin
      bus.o_Cpu_Ready  <= cpu_ready_d;
      bus.o_Cpu_Hit    <= cpu_hit_d;
      bus.o_Bus_Req    <= bus_req_d;
      bus.o_Bus_Valid  <= bus_valid_d;
      bus.o_Operation  <= operation_d;
      bus.o_Bus_Addr   <= bus_addr_d;
      bus.o_Writeback  <= writeback_d;
      bus.o_Wb_Addr    <= wb_addr_d;
      bus.o_Flush      <= flush_d;
      bus.o_Flush_Addr <= flush_addr_d;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        line_state[i] <= LS_I;
        line_tag[i]   <= '0;
      end
    end else begin
      if (snp_apply && snp_kill)
        line_state[snp_idx] <= LS_I;
      else if (snp_apply && snp_down)
        line_state[snp_idx] <= LS_S;
      if (state == WRITEBACK) begin
        line_state[req_idx] <= LS_I;
      end else if (state == BUS_ISSUE) begin
        line_tag[req_idx]   <= req_tag;
        line_state[req_idx] <= (pend_op == OP_READ_MISS) ? LS_S : LS_M;
      end
    end
  end
endmodule

// File: tb/tb_emissor.sv
// Self-checking bench for emissor: directed MSI scenarios plus random traffic
// checked cycle by cycle against a transaction-level cache model.
module tb_emissor;
  localparam int unsigned INDEX_W = 2;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned A       = TAG_W + INDEX_W;
  localparam int unsigned LINES   = 1 << INDEX_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  emissor_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();
  emissor #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Model: 0 = I, 1 = S, 2 = M
  int m_st [LINES];
  int m_tg [LINES];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_st[i] = 0;
      m_tg[i] = 0;
    end
  endtask

  function automatic logic [63:0] raw_vec();
    return {37'b0, bus.o_Cpu_Ready, bus.o_Cpu_Hit, bus.o_Bus_Req, bus.o_Bus_Valid,
            bus.o_Operation, bus.o_Bus_Addr, bus.o_Writeback, bus.o_Wb_Addr,
            bus.o_Flush, bus.o_Flush_Addr};
  endfunction

  function automatic logic [63:0] obs_vec(input logic eready, input logic evalid, input logic ewb);
    return {44'b0, bus.o_Cpu_Ready, eready ? bus.o_Cpu_Hit : 1'b0, bus.o_Bus_Req,
            bus.o_Bus_Valid, evalid ? bus.o_Operation : 2'b00,
            evalid ? bus.o_Bus_Addr : 6'b0, bus.o_Writeback,
            ewb ? bus.o_Wb_Addr : 6'b0, bus.o_Flush};
  endfunction

  // One CPU transaction; g = cycles of late grant; optional snoop in cycle N+snp_at.
  task automatic txn(input logic wr, input logic [A-1:0] addr, input int g,
                     input int snp_at, input logic [1:0] snp_op, input logic [A-1:0] snp_addr);
    int idx, tg, n_req, n_valid, n_ready;
    logic hit, use_bus, wb, ereq, evalid, eready, ewb;
    logic [1:0] op;
    logic [A-1:0] wb_addr;
    logic [63:0] e;
    idx     = int'(addr[1:0]);
    tg      = int'(addr[5:2]);
    hit     = (m_st[idx] != 0) && (m_tg[idx] == tg);
    use_bus = 1'b1;
    wb      = 1'b0;
    op      = 2'b00;
    if (hit && (!wr || m_st[idx] == 2)) use_bus = 1'b0;
    else if (hit) op = 2'b01;
    else begin
      wb = (m_st[idx] == 2);
      op = wr ? 2'b10 : 2'b00;
    end
    wb_addr = A'(m_tg[idx] * 4 + idx);
    n_req   = 2 + int'(wb);
    n_valid = 3 + int'(wb) + g;
    n_ready = use_bus ? 4 + int'(wb) + g : 2;
    if (op == 2'b01 && snp_at >= 1 && snp_at <= n_valid - 1 &&
        (snp_op == 2'b01 || snp_op == 2'b10) && snp_addr == addr)
      op = 2'b10;

    bus.i_Cpu_Valid = 1'b1;
    bus.i_Cpu_Write = wr;
    bus.i_Cpu_Addr  = addr;
    bus.i_Bus_Grant = (g == 0);
    step();
    for (int c = 1; c <= n_ready + 1; c++) begin
      bus.i_Snoop_Valid     = (c == snp_at);
      bus.i_Snoop_Operation = snp_op;
      bus.i_Snoop_Addr      = snp_addr;
      ereq   = use_bus && c >= n_req && c < n_valid;
      evalid = use_bus && c == n_valid;
      eready = (c == n_ready);
      ewb    = wb && c == 2;
      e = {44'b0, eready, eready && !use_bus, ereq, evalid, evalid ? op : 2'b00,
           evalid ? addr : 6'b0, ewb, ewb ? wb_addr : 6'b0, 1'b0};
      chk($sformatf("txn %s %0h c%0d", wr ? "wr" : "rd", addr, c), obs_vec(eready, evalid, ewb), e);
      bus.i_Bus_Grant = (c >= n_valid - 1) || (g == 0);
      if (eready) bus.i_Cpu_Valid = 1'b0;
      step();
    end
    bus.i_Snoop_Valid = 1'b0;
    if (use_bus) begin
      m_st[idx] = (op == 2'b00) ? 1 : 2;
      m_tg[idx] = tg;
    end
  endtask

  task automatic snoop(input logic [1:0] op, input logic [A-1:0] addr);
    int idx, tg;
    logic match, eflush;
    idx    = int'(addr[1:0]);
    tg     = int'(addr[5:2]);
    match  = (op != 2'b11) && (m_st[idx] != 0) && (m_tg[idx] == tg);
    eflush = match && op == 2'b00 && m_st[idx] == 2;
    bus.i_Snoop_Valid     = 1'b1;
    bus.i_Snoop_Operation = op;
    bus.i_Snoop_Addr      = addr;
    step();
    bus.i_Snoop_Valid = 1'b0;
    chk($sformatf("flush op%0d %0h", op, addr),
        {57'b0, bus.o_Flush, eflush ? bus.o_Flush_Addr : 6'b0},
        {57'b0, eflush, eflush ? addr : 6'b0});
    if (match && op == 2'b00 && m_st[idx] == 2) m_st[idx] = 1;
    else if (match && op != 2'b00) m_st[idx] = 0;
    step();
    chk("flush width", {63'b0, bus.o_Flush}, 64'd0);
  endtask

  initial begin
    bus.i_Cpu_Valid       = 1'b0;
    bus.i_Cpu_Write       = 1'b0;
    bus.i_Cpu_Addr        = '0;
    bus.i_Bus_Grant       = 1'b1;
    bus.i_Snoop_Valid     = 1'b0;
    bus.i_Snoop_Operation = 2'b00;
    bus.i_Snoop_Addr      = '0;
    model_reset();
    repeat (2) step();
    chk("reset outputs", raw_vec(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    txn(1'b0, 6'h13, 0, 0, 2'b00, 6'h00);   // READ_MISS, line 3 -> S
    txn(1'b0, 6'h13, 0, 0, 2'b00, 6'h00);   // read hit
    txn(1'b1, 6'h13, 0, 0, 2'b00, 6'h00);   // INVALIDATE, line 3 -> M
    txn(1'b1, 6'h13, 0, 0, 2'b00, 6'h00);   // write hit
    txn(1'b1, 6'h23, 0, 0, 2'b00, 6'h00);   // writeback 0x13, WRITE_MISS 0x23
    snoop(2'b00, 6'h23);                    // M -> S with flush
    snoop(2'b10, 6'h23);                    // S -> I
    txn(1'b0, 6'h23, 0, 0, 2'b00, 6'h00);   // refill in S
    txn(1'b1, 6'h23, 3, 3, 2'b01, 6'h23);   // INVALIDATE lost in BUS_REQ -> WRITE_MISS

    // Reset while waiting for grant
    txn(1'b0, 6'h05, 0, 0, 2'b00, 6'h00);
    bus.i_Cpu_Valid = 1'b1;
    bus.i_Cpu_Write = 1'b0;
    bus.i_Cpu_Addr  = 6'h09;
    bus.i_Bus_Grant = 1'b0;
    repeat (3) step();
    chk("bus_req before reset", {63'b0, bus.o_Bus_Req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("outputs in reset", raw_vec(), 64'd0);
    bus.i_Cpu_Valid = 1'b0;
    bus.i_Bus_Grant = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("quiet after reset", {61'b0, bus.o_Cpu_Ready, bus.o_Bus_Valid, bus.o_Bus_Req}, 64'd0);
    end
    txn(1'b0, 6'h05, 0, 0, 2'b00, 6'h00);   // line 1 was cleared: miss
    txn(1'b1, 6'h23, 0, 0, 2'b00, 6'h00);   // line 3 was cleared: no writeback

    for (int i = 0; i < 60; i++) begin
      logic [A-1:0] a;
      int unsigned roll;
      a    = A'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
      roll = $urandom_range(0, 2);
      if (roll == 0)
        snoop(2'($urandom_range(0, 3)), a);
      else
        txn(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 2)), 0, 2'b00, 6'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
